// File: rtl/cmd_dispatch_fsm_if.sv
// Host command / response handshake plus the fan-out to the GET/PUT/DEL
// operation FSMs, bundled for the command dispatcher.
interface cmd_dispatch_fsm_if #(
  parameter int KEY_W = 32,
  parameter int VAL_W = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [KEY_W-1:0] cmd_key;
  logic [VAL_W-1:0] cmd_val;
  logic [KEY_W-1:0] op_key;
  logic [VAL_W-1:0] op_val;
  logic             get_enter;
  logic             put_enter;
  logic             del_enter;
  logic             get_en;
  logic             put_en;
  logic             del_en;
  logic             get_done;
  logic             put_done;
  logic             del_done;
  logic             sub_hit;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_status;

  // Host / operation-FSM side.
  modport master (
    output cmd_valid, cmd_op, cmd_key, cmd_val,
    output get_done, put_done, del_done, sub_hit, rsp_ready,
    input  cmd_ready, op_key, op_val,
    input  get_enter, put_enter, del_enter, get_en, put_en, del_en,
    input  rsp_valid, rsp_status
  );

  // Dispatcher side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_key, cmd_val,
    input  get_done, put_done, del_done, sub_hit, rsp_ready,
    output cmd_ready, op_key, op_val,
    output get_enter, put_enter, del_enter, get_en, put_en, del_en,
    output rsp_valid, rsp_status
  );
endinterface

// File: rtl/cmd_dispatch_fsm.sv
// Single-outstanding command dispatcher: latches a host command, pulses the
// selected operation FSM's enter, enables it until done or timeout, then responds.
module cmd_dispatch_fsm #(
  parameter int KEY_W       = 32,
  parameter int VAL_W       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  cmd_dispatch_fsm_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_GET = 2'd1;
  localparam logic [1:0] OP_PUT = 2'd2;
  localparam logic [1:0] OP_DEL = 2'd3;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_MISS    = 2'd1;
  localparam logic [1:0] ST_ERR     = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTER = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic [1:0]       status_q, status_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_done_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      key_q    <= {KEY_W{1'b0}};
      val_q    <= {VAL_W{1'b0}};
      status_q <= ST_OK;
      cnt_q    <= CNT_ZERO;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      key_q    <= key_d;
      val_q    <= val_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end

  // Only the done line of the latched operation is ever looked at.
  always_comb begin
    sel_done_s = 1'b0;
    case (op_q)
      OP_GET:  sel_done_s = bus.get_done;
      OP_PUT:  sel_done_s = bus.put_done;
      OP_DEL:  sel_done_s = bus.del_done;
      default: sel_done_s = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    key_d    = key_q;
    val_d    = val_q;
    status_d = status_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d  = bus.cmd_op;
          key_d = bus.cmd_key;
          val_d = bus.cmd_val;
          if (bus.cmd_op == OP_NOP) begin
            state_d  = S_RESP;
            status_d = ST_ERR;
          end else begin
            state_d  = S_ENTER;
            status_d = ST_OK;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ENTER: begin
        cnt_d   = CNT_ZERO;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        // Counter tops out at TIMEOUT_CYC on the exit cycle, so it cannot wrap.
        cnt_d = cnt_q + CNT_ONE;
        if (sel_done_s) begin
          state_d = S_RESP;
          if (op_q == OP_PUT) begin
            status_d = ST_OK;
          end else if (bus.sub_hit) begin
            status_d = ST_OK;
          end else begin
            status_d = ST_MISS;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d  = S_RESP;
          status_d = ST_TIMEOUT;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.cmd_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.get_enter  = 1'b0;
    bus.put_enter  = 1'b0;
    bus.del_enter  = 1'b0;
    bus.get_en     = 1'b0;
    bus.put_en     = 1'b0;
    bus.del_en     = 1'b0;
    bus.op_key     = key_q;
    bus.op_val     = val_q;
    bus.rsp_status = status_q;
    case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
      end
      S_ENTER: begin
        bus.get_enter = (op_q == OP_GET);
        bus.put_enter = (op_q == OP_PUT);
        bus.del_enter = (op_q == OP_DEL);
      end
      S_BUSY: begin
        bus.get_en = (op_q == OP_GET);
        bus.put_en = (op_q == OP_PUT);
        bus.del_en = (op_q == OP_DEL);
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
      end
      default: begin
        bus.cmd_ready = 1'b0;
      end
    endcase
  end
endmodule
